pa_core_trap_ctrl: RTL and testbench
====================================

# pa_core_trap_ctrl

Parametrised machine-mode trap controller, successor to the core's single-line interrupt unit. Sits between the execute stage and the CSR file, arbitrating synchronous exceptions (ecall/ebreak), mret, up to IRQ_NUM external interrupt lines with per-line enable/pending, and the mstatus soft-interrupt bit. Once arbitration picks a trap, the block sequences the mepc/mstatus/mcause CSR writes and redirects fetch, with optional vectored dispatch.

## Interface
- IRQ_NUM, 4: external interrupt lines, legal 1..16
- DATA_W, 32: data/address width
- CSR_W, 12: CSR address width
- VECTORED, 1: 1 enables vectored dispatch when mtvec[1:0]==2'b01; 0 forces direct mode
- clk_i  in  1  core clock
- rst_i  in  1  reset. One clock; reset is synchronous and active-high.
- inst_set_i  in  1  RV32I instruction valid
- inst_func_i  in  3  [2] ecall, [1] ebreak, [0] mret
- pc_i  in  DATA_W  current pc
- jump_flag_i / jump_addr_i  in  1 / DATA_W  branch in flight, target
- csr_mtvec_i, csr_mepc_i, csr_mstatus_i  in  DATA_W  CSR values
- csr_mie_i  in  IRQ_NUM  per-line enable
- irq_i  in  IRQ_NUM  asynchronous interrupt lines
- csr_waddr_o  out  CSR_W  CSR write address
- csr_waddr_vld_o  out  1  CSR write strobe
- csr_wdata_o  out  DATA_W  CSR write data
- hold_flag_o  out  1  pipeline hold
- int_req_o  out  1  one-cycle fetch redirect
- int_addr_o  out  DATA_W  redirect target
- irq_pend_o  out  IRQ_NUM  pending bits (mip view)

## Operation
- **Input sync:** each irq_i line goes through a 2-flop synchroniser. A rising edge of the synchronised line sets pend[k].
- **Pending clear:** pend[k] clears on the cycle line k is accepted. A new edge in the same cycle wins, so the bit stays set.
- **Arbitration priority** (combinational, sampled only when state==IDLE):
  - ecall/ebreak, then mret, then lowest-index k with pend[k] & csr_mie_i[k] & mstatus.MIE, then soft int (mstatus[31] & MIE).
  - ecall and ebreak both set: ecall wins.
- **Causes:**
  - ecall: 11
  - ebreak: 3
  - irq k: 0x8000_0000 | (16+k)
  - soft int: 0x8000_0003
- **EPC:** jump_flag_i ? jump_addr_i−4 : pc_i−8, modulo 2^DATA_W. The handler adds 4.
- **Target:**
  - mret: csr_mepc_i.
  - Direct mode: {mtvec[DATA_W−1:2],2'b00}.
  - Vectored mode, interrupts only: base + 4×(cause[4:0]). Exceptions always go to base.
- **FSM states:** IDLE, MEPC, MSTATUS, MCAUSE, MRET.
  - IDLE→MEPC on a trap; epc, cause and target are captured.
  - IDLE→MRET on mret.
  - MEPC→MSTATUS→MCAUSE→IDLE.
  - MRET→IDLE.
  - Illegal encodings go →IDLE.
- **Registered outputs,** driven from the state of the previous cycle:
  - MEPC: write mepc=epc.
  - MSTATUS: write mstatus with MPIE[7]←MIE[3], MIE←0, other bits unchanged.
  - MCAUSE: write mcause=cause; int_req_o=1, int_addr_o=target.
  - MRET: write mstatus with MIE←MPIE, MPIE←1; int_req_o=1, int_addr_o=csr_mepc_i.
  - Otherwise: vld=0, addr=0, data=0.
- **hold_flag_o** = (state!=IDLE) | csr_waddr_vld_o.
- **Requests outside IDLE:** exception/mret decodes are ignored, because the held instruction re-presents. IRQ edges still latch into pend.

## Timing
- **Reset values:** every output 0; state=IDLE; pend=0; synchroniser flops 0. Reset mid-sequence aborts with no further CSR writes.
- **Trap latency:** decode at edge 0 → state MEPC at edge 1 → writes at cycles 2, 3, 4 (mepc, mstatus, mcause). int_req_o pulses in cycle 4, together with the mcause write.
- **mret latency:** edge 1 state MRET → cycle 2 mstatus write + int_req_o.
- **IRQ latency:** irq_i rise → pend set 3 edges later (2 sync + edge detect). Trap decode can happen on the next edge.
- **Back-to-back:** a new trap can be accepted in the IDLE cycle following MCAUSE. hold_flag_o stays high through the last write cycle.
- **Level lines:** a line held high produces exactly one pend.

## Structure
- Shared constants go in pa_chip_param.v: state codes, cause codes, CSR_MEPC/MSTATUS/MCAUSE addresses, VALID/INVALID, ZERO_WORD.
- One sub-module, pa_core_prio_enc #(N): lowest-index-first encoder with a valid output and a 4-bit index.

## Test plan
- **ecall:** pc_i=0x100, no jump → mepc=0xF8, mstatus MIE 1→0 with MPIE=1, mcause=11, int_req_o with addr=mtvec 0x200 in cycle 4.
- **Simultaneous IRQs, vectored:** irq[2] and irq[1] rise together, mie=4'hF, MIE=1, mtvec=0x201 → cause 0x8000_0011, target 0x244. After the sequence, pend[2] is still set and is taken next.
- **Masked line:** mie[0]=0, irq[0] rises → no trap; irq_pend_o[0]=1 persists. Setting mie[0] later → cause 0x8000_0010.
- **mret:** mstatus=0x80 → mstatus write 0x88, int_req_o with addr=csr_mepc_i, 2-cycle hold.
- **Busy and mid-sequence reset:** ecall and an irq edge together → ecall first, then the irq with jump_flag_i=1 and jump_addr_i=0x400 → mepc=0x3FC. Asserting rst_i in state MSTATUS gives all outputs 0 the next cycle.

Source files
------------

// File: rtl/pa_core_trap_ctrl_pkg.sv
// Shared constants for the machine-mode trap controller: FSM state codes,
// CSR addresses, cause codes and mstatus bit positions.
package pa_core_trap_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MEPC    = 3'd1,
        ST_MSTATUS = 3'd2,
        ST_MCAUSE  = 3'd3,
        ST_MRET    = 3'd4
    } trap_state_e;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    // Low five cause bits; the interrupt flag lives in the top data bit.
    localparam logic [4:0] CAUSE_ECALL  = 5'd11;
    localparam logic [4:0] CAUSE_EBREAK = 5'd3;
    localparam logic [4:0] CAUSE_SOFT   = 5'd3;

    localparam logic VALID   = 1'b1;
    localparam logic INVALID = 1'b0;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MSTATUS_SOFT = 31;

endpackage

// File: rtl/pa_core_trap_ctrl_prio_enc.sv
// Lowest-index-first priority encoder; idx_o is the first set request bit.
module pa_core_prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] req_i,
    output logic         vld_o,
    output logic [3:0]   idx_o
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        vld_o = 1'b0;
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                vld_o = 1'b1;
                idx_o = 4'(i);
            end
        end
    end

endmodule

// File: rtl/pa_core_trap_ctrl.sv
// Machine-mode trap controller: arbitrates exceptions, mret and interrupts,
// then sequences the mepc/mstatus/mcause writes and redirects fetch.
module pa_core_trap_ctrl
    import pa_core_trap_ctrl_pkg::*;
#(
    parameter int IRQ_NUM  = 4,
    parameter int DATA_W   = 32,
    parameter int CSR_W    = 12,
    parameter int VECTORED = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               inst_set_i,
    input  logic [2:0]         inst_func_i,
    input  logic [DATA_W-1:0]  pc_i,
    input  logic               jump_flag_i,
    input  logic [DATA_W-1:0]  jump_addr_i,
    input  logic [DATA_W-1:0]  csr_mtvec_i,
    input  logic [DATA_W-1:0]  csr_mepc_i,
    input  logic [DATA_W-1:0]  csr_mstatus_i,
    input  logic [IRQ_NUM-1:0] csr_mie_i,
    input  logic [IRQ_NUM-1:0] irq_i,
    output logic [CSR_W-1:0]   csr_waddr_o,
    output logic               csr_waddr_vld_o,
    output logic [DATA_W-1:0]  csr_wdata_o,
    output logic               hold_flag_o,
    output logic               int_req_o,
    output logic [DATA_W-1:0]  int_addr_o,
    output logic [IRQ_NUM-1:0] irq_pend_o
);

    trap_state_e        state_q, state_d;
    logic [IRQ_NUM-1:0] sync1_q, sync2_q, sync3_q;
    logic [IRQ_NUM-1:0] pend_q, pend_d, pend_clr;
    logic [IRQ_NUM-1:0] irq_req, irq_ack;
    logic               irq_vld;
    logic [3:0]         irq_idx;
    logic [DATA_W-1:0]  epc_q, epc_d, cause_q, cause_d, target_q, target_d;
    logic [DATA_W-1:0]  trap_cause, trap_base;
    logic               trap_take, exc_req, mret_req, soft_req, vec_mode;
    logic [CSR_W-1:0]   waddr_q, waddr_d;
    logic               wvld_q, wvld_d, int_req_q, int_req_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d, int_addr_q, int_addr_d;

    assign irq_req = pend_q & csr_mie_i & {IRQ_NUM{csr_mstatus_i[MSTATUS_MIE]}};

    pa_core_prio_enc #(.N(IRQ_NUM)) u_prio_enc (
        .req_i (irq_req),
        .vld_o (irq_vld),
        .idx_o (irq_idx)
    );

    always_comb begin
        exc_req    = inst_set_i & (inst_func_i[2] | inst_func_i[1]);
        mret_req   = inst_set_i & inst_func_i[0];
        soft_req   = csr_mstatus_i[MSTATUS_SOFT] & csr_mstatus_i[MSTATUS_MIE];
        vec_mode   = (VECTORED != 0) && (csr_mtvec_i[1:0] == 2'b01);
        trap_base  = {csr_mtvec_i[DATA_W-1:2], 2'b00};
        trap_cause = '0;
        trap_take  = INVALID;
        irq_ack    = '0;
        if (exc_req) begin
            trap_take       = VALID;
            trap_cause[4:0] = inst_func_i[2] ? CAUSE_ECALL : CAUSE_EBREAK;
        end else if (!mret_req) begin
            if (irq_vld) begin
                trap_take              = VALID;
                trap_cause[DATA_W-1]   = 1'b1;
                trap_cause[4:0]        = {1'b1, irq_idx};
                irq_ack                = IRQ_NUM'(1) << irq_idx;
            end else if (soft_req) begin
                trap_take              = VALID;
                trap_cause[DATA_W-1]   = 1'b1;
                trap_cause[4:0]        = CAUSE_SOFT;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        epc_d    = epc_q;
        cause_d  = cause_q;
        target_d = target_q;
        pend_clr = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (trap_take) begin
                    state_d  = ST_MEPC;
                    epc_d    = jump_flag_i ? jump_addr_i - DATA_W'(4) : pc_i - DATA_W'(8);
                    cause_d  = trap_cause;
                    target_d = (vec_mode && trap_cause[DATA_W-1])
                             ? trap_base + DATA_W'({trap_cause[4:0], 2'b00})
                             : trap_base;
                    pend_clr = irq_ack;
                end else if (mret_req) begin
                    state_d = ST_MRET;
                end
            end
            ST_MEPC:    state_d = ST_MSTATUS;
            ST_MSTATUS: state_d = ST_MCAUSE;
            ST_MCAUSE:  state_d = ST_IDLE;
            ST_MRET:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        // A fresh edge in the acceptance cycle keeps the bit set.
        pend_d = (pend_q & ~pend_clr) | (sync2_q & ~sync3_q);
    end

    always_comb begin
        wvld_d     = INVALID;
        waddr_d    = '0;
        wdata_d    = '0;
        int_req_d  = INVALID;
        int_addr_d = '0;
        case (state_q)
            ST_MEPC: begin
                wvld_d  = VALID;
                waddr_d = CSR_W'(CSR_MEPC);
                wdata_d = epc_q;
            end
            ST_MSTATUS: begin
                wvld_d                = VALID;
                waddr_d               = CSR_W'(CSR_MSTATUS);
                wdata_d               = csr_mstatus_i;
                wdata_d[MSTATUS_MPIE] = csr_mstatus_i[MSTATUS_MIE];
                wdata_d[MSTATUS_MIE]  = 1'b0;
            end
            ST_MCAUSE: begin
                wvld_d     = VALID;
                waddr_d    = CSR_W'(CSR_MCAUSE);
                wdata_d    = cause_q;
                int_req_d  = VALID;
                int_addr_d = target_q;
            end
            ST_MRET: begin
                wvld_d                = VALID;
                waddr_d               = CSR_W'(CSR_MSTATUS);
                wdata_d               = csr_mstatus_i;
                wdata_d[MSTATUS_MIE]  = csr_mstatus_i[MSTATUS_MPIE];
                wdata_d[MSTATUS_MPIE] = 1'b1;
                int_req_d             = VALID;
                int_addr_d            = csr_mepc_i;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            sync1_q    <= '0;
            sync2_q    <= '0;
            sync3_q    <= '0;
            pend_q     <= '0;
            epc_q      <= '0;
            cause_q    <= '0;
            target_q   <= '0;
            wvld_q     <= INVALID;
            waddr_q    <= '0;
            wdata_q    <= '0;
            int_req_q  <= INVALID;
            int_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= irq_i;
            sync2_q    <= sync1_q;
            sync3_q    <= sync2_q;
            pend_q     <= pend_d;
            epc_q      <= epc_d;
            cause_q    <= cause_d;
            target_q   <= target_d;
            wvld_q     <= wvld_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            int_req_q  <= int_req_d;
            int_addr_q <= int_addr_d;
        end
    end

    assign csr_waddr_o     = waddr_q;
    assign csr_waddr_vld_o = wvld_q;
    assign csr_wdata_o     = wdata_q;
    assign int_req_o       = int_req_q;
    assign int_addr_o      = int_addr_q;
    assign irq_pend_o      = pend_q;
    assign hold_flag_o     = (state_q != ST_IDLE) | wvld_q;

endmodule

// File: tb/tb_pa_core_trap_ctrl.sv
// Self-checking bench: directed trap scenarios plus random traffic, all
// compared cycle by cycle against a transaction-level reference model.
module tb_pa_core_trap_ctrl;

    localparam int IRQ_NUM = 4;
    localparam int DATA_W  = 32;
    localparam int CSR_W   = 12;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               inst_set_i;
    logic [2:0]         inst_func_i;
    logic [DATA_W-1:0]  pc_i, jump_addr_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
    logic               jump_flag_i;
    logic [IRQ_NUM-1:0] csr_mie_i, irq_i;
    logic [CSR_W-1:0]   csr_waddr_o;
    logic               csr_waddr_vld_o, hold_flag_o, int_req_o;
    logic [DATA_W-1:0]  csr_wdata_o, int_addr_o;
    logic [IRQ_NUM-1:0] irq_pend_o;

    int n_tests = 0;
    int n_fail  = 0;

    pa_core_trap_ctrl #(
        .IRQ_NUM(IRQ_NUM), .DATA_W(DATA_W), .CSR_W(CSR_W), .VECTORED(1)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .inst_set_i(inst_set_i), .inst_func_i(inst_func_i),
        .pc_i(pc_i), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i), .csr_mstatus_i(csr_mstatus_i),
        .csr_mie_i(csr_mie_i), .irq_i(irq_i), .csr_waddr_o(csr_waddr_o),
        .csr_waddr_vld_o(csr_waddr_vld_o), .csr_wdata_o(csr_wdata_o),
        .hold_flag_o(hold_flag_o), .int_req_o(int_req_o), .int_addr_o(int_addr_o),
        .irq_pend_o(irq_pend_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: trap sequences are scheduled as offsets from the
    // acceptance edge; irq history is a plain sample shift list.
    int          edge_n = 0, free_edge = 0, hold_last = -1, seq_m = -100, seq_kind = 0;
    logic [31:0] seq_epc, seq_cause, seq_target;
    logic [3:0]  pend_m = '0, h0 = '0, h1 = '0, h2 = '0;
    logic        exp_vld, exp_req, exp_hold;
    logic [11:0] exp_waddr;
    logic [31:0] exp_wdata, exp_iaddr;
    logic [3:0]  exp_pend;
    bit          chk_en = 0;

    always @(posedge clk_i) begin : model
        logic [3:0]  ack, rise;
        logic [31:0] mst, cause, base;
        int          d;
        bit          take, found;
        mst = csr_mstatus_i;
        exp_vld = 0; exp_waddr = '0; exp_wdata = '0; exp_req = 0; exp_iaddr = '0;
        if (rst_i) begin
            pend_m = '0; h0 = '0; h1 = '0; h2 = '0;
            seq_kind = 0; free_edge = edge_n + 1; hold_last = -1;
        end else begin
            d = edge_n - seq_m;
            if (seq_kind == 1 && d == 1) begin
                exp_vld = 1; exp_waddr = 12'h341; exp_wdata = seq_epc;
            end else if (seq_kind == 1 && d == 2) begin
                exp_vld = 1; exp_waddr = 12'h300;
                exp_wdata = (mst & ~32'h88) | (mst[3] ? 32'h80 : 32'h0);
            end else if (seq_kind == 1 && d == 3) begin
                exp_vld = 1; exp_waddr = 12'h342; exp_wdata = seq_cause;
                exp_req = 1; exp_iaddr = seq_target;
            end else if (seq_kind == 2 && d == 1) begin
                exp_vld = 1; exp_waddr = 12'h300;
                exp_wdata = (mst & ~32'h88) | 32'h80 | (mst[7] ? 32'h8 : 32'h0);
                exp_req = 1; exp_iaddr = csr_mepc_i;
            end
            ack = '0; take = 0; found = 0; cause = '0;
            if (edge_n >= free_edge) begin
                if (inst_set_i && (inst_func_i[2] || inst_func_i[1])) begin
                    take = 1; cause = inst_func_i[2] ? 32'd11 : 32'd3;
                end else if (inst_set_i && inst_func_i[0]) begin
                    seq_kind = 2; seq_m = edge_n; free_edge = edge_n + 2; hold_last = edge_n + 1;
                end else if (mst[3]) begin
                    for (int k = 0; k < IRQ_NUM; k++) begin
                        if (!found && pend_m[k] && csr_mie_i[k]) begin
                            found = 1; ack[k] = 1'b1; cause = 32'h8000_0000 | 32'(16 + k);
                        end
                    end
                    if (found) take = 1;
                    else if (mst[31]) begin take = 1; cause = 32'h8000_0003; end
                end
            end
            if (take) begin
                base       = csr_mtvec_i & ~32'd3;
                seq_kind   = 1; seq_m = edge_n; seq_cause = cause;
                seq_epc    = jump_flag_i ? jump_addr_i - 32'd4 : pc_i - 32'd8;
                seq_target = (csr_mtvec_i[1:0] == 2'b01 && cause[31]) ? base + 4 * (cause & 32'd31) : base;
                free_edge  = edge_n + 4; hold_last = edge_n + 3;
            end
            rise   = h1 & ~h2;
            pend_m = (pend_m & ~ack) | rise;
            h2 = h1; h1 = h0; h0 = irq_i;
        end
        exp_pend = pend_m;
        exp_hold = (edge_n <= hold_last);
        edge_n++;
        chk_en = 1;
    end

    always @(negedge clk_i) begin
        if (chk_en) begin
            check("vld",      64'(csr_waddr_vld_o), 64'(exp_vld));
            check("waddr",    64'(csr_waddr_o),     64'(exp_waddr));
            check("wdata",    64'(csr_wdata_o),     64'(exp_wdata));
            check("int_req",  64'(int_req_o),       64'(exp_req));
            check("int_addr", 64'(int_addr_o),      64'(exp_iaddr));
            check("pend",     64'(irq_pend_o),      64'(exp_pend));
            check("hold",     64'(hold_flag_o),     64'(exp_hold));
        end
    end

    task automatic wait_int(input int max_cyc, output bit seen);
        seen = 0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk_i);
            if (int_req_o) seen = 1;
        end
    endtask

    initial begin
        bit seen;
        int hold_cnt;
        logic [31:0] mret_data, mret_addr;
        rst_i = 1; inst_set_i = 0; inst_func_i = '0; pc_i = 32'h100; jump_flag_i = 0;
        jump_addr_i = '0; csr_mtvec_i = 32'h200; csr_mepc_i = '0; csr_mstatus_i = 32'h8;
        csr_mie_i = '0; irq_i = '0;
        repeat (3) @(negedge clk_i);
        check("rst_vld", 64'(csr_waddr_vld_o), 64'd0);
        check("rst_hold", 64'(hold_flag_o), 64'd0);
        check("rst_pend", 64'(irq_pend_o), 64'd0);
        rst_i = 0;
        repeat (2) @(negedge clk_i);

        // ecall from pc 0x100
        inst_set_i = 1; inst_func_i = 3'b100;
        @(negedge clk_i); inst_set_i = 0;
        check("ecall_hold", 64'(hold_flag_o), 64'd1);
        @(negedge clk_i);
        check("ecall_mepc_addr", 64'(csr_waddr_o), 64'h341);
        check("ecall_mepc", 64'(csr_wdata_o), 64'hF8);
        @(negedge clk_i);
        check("ecall_mstatus", 64'(csr_wdata_o), 64'h80);
        @(negedge clk_i);
        check("ecall_mcause", 64'(csr_wdata_o), 64'd11);
        check("ecall_req", 64'(int_req_o), 64'd1);
        check("ecall_target", 64'(int_addr_o), 64'h200);

        // two lines together, vectored dispatch
        csr_mtvec_i = 32'h201; csr_mie_i = 4'hF; irq_i = 4'b0110;
        wait_int(20, seen);
        check("vec1_seen", 64'(seen), 64'd1);
        check("vec1_cause", 64'(csr_wdata_o), 64'h8000_0011);
        check("vec1_target", 64'(int_addr_o), 64'h244);
        check("vec1_pend_left", 64'(irq_pend_o), 64'b0100);
        wait_int(20, seen);
        check("vec2_seen", 64'(seen), 64'd1);
        check("vec2_cause", 64'(csr_wdata_o), 64'h8000_0012);
        check("vec2_target", 64'(int_addr_o), 64'h248);

        // masked line stays pending until enabled
        irq_i = '0; csr_mie_i = 4'b1110;
        repeat (5) @(negedge clk_i);
        irq_i = 4'b0001;
        wait_int(12, seen);
        check("masked_no_trap", 64'(seen), 64'd0);
        check("masked_pend", 64'(irq_pend_o), 64'b0001);
        csr_mie_i = 4'hF;
        wait_int(20, seen);
        check("unmask_seen", 64'(seen), 64'd1);
        check("unmask_cause", 64'(csr_wdata_o), 64'h8000_0010);

        // mret
        irq_i = '0;
        repeat (4) @(negedge clk_i);
        csr_mstatus_i = 32'h80; csr_mepc_i = 32'h1234;
        inst_set_i = 1; inst_func_i = 3'b001;
        hold_cnt = 0; mret_data = '0; mret_addr = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            inst_set_i = 0;
            hold_cnt += int'(hold_flag_o);
            if (int_req_o) begin mret_data = csr_wdata_o; mret_addr = int_addr_o; end
        end
        check("mret_wdata", 64'(mret_data), 64'h88);
        check("mret_target", 64'(mret_addr), 64'h1234);
        check("mret_hold_cycles", 64'(hold_cnt), 64'd2);

        // busy: ecall first, then the irq after a taken branch; then reset mid-sequence
        csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h200;
        inst_set_i = 1; inst_func_i = 3'b100; pc_i = 32'h100; irq_i = 4'b0010;
        @(negedge clk_i);
        inst_set_i = 0; jump_flag_i = 1; jump_addr_i = 32'h400;
        wait_int(10, seen);
        check("busy_ecall_cause", 64'(csr_wdata_o), 64'd11);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk_i);
            if (csr_waddr_vld_o && csr_waddr_o == 12'h341) seen = 1;
        end
        check("busy_irq_seen", 64'(seen), 64'd1);
        check("busy_irq_mepc", 64'(csr_wdata_o), 64'h3FC);
        rst_i = 1;
        @(negedge clk_i);
        check("midrst_vld", 64'(csr_waddr_vld_o), 64'd0);
        check("midrst_wdata", 64'(csr_wdata_o), 64'd0);
        check("midrst_req", 64'(int_req_o), 64'd0);
        check("midrst_hold", 64'(hold_flag_o), 64'd0);
        rst_i = 0; jump_flag_i = 0; irq_i = '0;
        repeat (6) @(negedge clk_i);

        // random traffic
        for (int c = 0; c < 1500; c++) begin
            rst_i         = ($urandom_range(249, 0) == 0);
            inst_set_i    = ($urandom_range(7, 0) == 0);
            inst_func_i   = 3'($urandom_range(7, 0));
            pc_i          = $urandom;
            jump_flag_i   = 1'($urandom_range(1, 0));
            jump_addr_i   = ($urandom_range(3, 0) == 0) ? 32'($urandom_range(7, 0)) : $urandom;
            csr_mtvec_i   = $urandom;
            csr_mepc_i    = $urandom;
            csr_mstatus_i = $urandom | (($urandom_range(3, 0) != 0) ? 32'h8 : 32'h0);
            csr_mie_i     = 4'($urandom_range(15, 0));
            for (int k = 0; k < IRQ_NUM; k++)
                if ($urandom_range(5, 0) == 0) irq_i[k] = ~irq_i[k];
            @(negedge clk_i);
        end
        rst_i = 0; inst_set_i = 0;
        repeat (8) @(negedge clk_i);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
